// File: rtl/pingpong_rd_ctrl_if.sv
// Read-side bus bundle of the ping-pong buffer: bank handshake with the write side,
// RAM read port and the valid/ready output stream.
interface pingpong_rd_ctrl_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
);
  logic [1:0]        bank_full;
  logic [1:0]        bank_release;
  logic              ram_en;
  logic [ADDR_W:0]   ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              rd_bank;
  logic              busy;

  modport master (
    input  bank_full, ram_dout, m_tready,
    output bank_release, ram_en, ram_addr, m_tdata, m_tvalid, m_tlast, rd_bank, busy
  );

  modport slave (
    output bank_full, ram_dout, m_tready,
    input  bank_release, ram_en, ram_addr, m_tdata, m_tvalid, m_tlast, rd_bank, busy
  );
endinterface

// File: rtl/pingpong_rd_ctrl.sv
// Drains full banks of the ping-pong RAM in strict 0/1 alternation and streams the words
// out; a 2-entry buffer absorbs the one-cycle RAM read latency under backpressure.
module pingpong_rd_ctrl #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  pingpong_rd_ctrl_if.master     bus
);

  localparam logic [ADDR_W-1:0] LAST_OFF = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RELEASE} state_t;

  state_t            state;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W:0]   issue_cnt;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] tail_data;
  logic              head_last;
  logic              tail_last;
  logic [1:0]        release_q;

  logic              issue;
  logic              pop;
  logic              push;
  logic [2:0]        pending;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    pop     = 1'b0;
    push    = inflight;
    pending = {1'b0, occ} + {2'b00, inflight};
    issue   = 1'b0;
    if (occ != 2'd0 && bus.m_tready) pop = 1'b1;
    // A read may only launch if its word is guaranteed a slot when it lands next cycle.
    if (state == STREAM && issue_cnt < DEPTH_CNT && pending < (3'd2 + {2'b00, pop}))
      issue = 1'b1;
  end

  assign bus.ram_en       = issue;
  assign bus.ram_addr     = {rd_bank_q, offset};
  assign bus.m_tvalid     = (occ != 2'd0);
  assign bus.m_tdata      = head_data;
  assign bus.m_tlast      = head_last;
  assign bus.rd_bank      = rd_bank_q;
  assign bus.busy         = (state != IDLE);
  assign bus.bank_release = release_q;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two buffer entries are reset because the head drives m_tdata/m_tlast
      // directly and those must read zero out of reset.
      state         <= IDLE;
      rd_bank_q     <= 1'b0;
      offset        <= '0;
      issue_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= 2'd0;
      head_data     <= '0;
      head_last     <= 1'b0;
      tail_data     <= '0;
      tail_last     <= 1'b0;
      release_q     <= 2'b00;
    end else begin
      release_q     <= 2'b00;
      inflight      <= issue;
      inflight_last <= issue && (offset == LAST_OFF);

      if (issue) begin
        issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
        if (offset != LAST_OFF) offset <= offset + ADDR_W'(1);
      end

      unique case ({push, pop})
        2'b10: begin
          occ <= occ + 2'd1;
          if (occ == 2'd0) begin
            head_data <= bus.ram_dout;
            head_last <= inflight_last;
          end else begin
            tail_data <= bus.ram_dout;
            tail_last <= inflight_last;
          end
        end
        2'b01: begin
          occ       <= occ - 2'd1;
          head_data <= tail_data;
          head_last <= tail_last && (occ == 2'd2);
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_data <= bus.ram_dout;
            head_last <= inflight_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= bus.ram_dout;
            tail_last <= inflight_last;
          end
        end
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          // Only the expected bank can start service; the other bank is never looked at.
          if (bus.bank_full[rd_bank_q]) begin
            state     <= STREAM;
            issue_cnt <= '0;
            offset    <= '0;
          end
        end
        STREAM: begin
          if (issue && issue_cnt == LAST_CNT) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && head_last) begin
            state     <= RELEASE;
            release_q <= rd_bank_q ? 2'b10 : 2'b01;
          end
        end
        RELEASE: begin
          rd_bank_q <= ~rd_bank_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  occ_bound_a: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

  stall_stable_a: assert property (@(posedge clk) disable iff (rst)
    (bus.m_tvalid && !bus.m_tready) |=> (bus.m_tvalid && $stable(bus.m_tdata) && $stable(bus.m_tlast)));

endmodule

// File: tb/tb_pingpong_rd_ctrl.sv
// Self-checking bench for pingpong_rd_ctrl: randomized backpressure, a RAM model returning
// its address, and expected streams derived from bank/offset arithmetic.
module tb_pingpong_rd_ctrl;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pingpong_rd_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pingpong_rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: data word equals its own address, one cycle after the read enable.
  always @(posedge clk)
    if (bus.ram_en) bus.ram_dout <= {{(DATA_W-ADDR_W-1){1'b0}}, bus.ram_addr};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Observations collected by stream_bank for one bank service.
  int   st_words[$];
  bit   st_lasts[$];
  int   st_addrs[$];
  int   st_c0, st_first_en, st_first_valid, st_last_hs, st_rel_cyc;
  int   st_stall_err, st_ovf;
  logic [1:0] st_rel_val, st_rel0;
  logic st_rd_bank0, st_valid0;
  bit   st_timeout;

  function automatic int exp_word(input int bank, input int k);
    return bank * DEPTH + k;
  endfunction

  task automatic cyc(input logic [1:0] bf, input logic rdy, input logic r);
    @(negedge clk);
    rst           = r;
    bus.bank_full = bf;
    bus.m_tready  = rdy;
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b1);
  endtask

  // Runs cycles until a release pulse is seen (or the budget expires), recording traffic.
  task automatic stream_bank(input logic [1:0] bf, input int low_pct, input int budget);
    int   issued = 0;
    int   popped = 0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    st_words.delete(); st_lasts.delete(); st_addrs.delete();
    st_first_en = -1; st_first_valid = -1; st_last_hs = -1; st_rel_cyc = -1;
    st_rel_val = 2'b00; st_stall_err = 0; st_ovf = 0; st_timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      cyc(bf, (int'($urandom_range(99)) >= low_pct), 1'b0);
      if (i == 0) begin
        st_c0 = cyc_n; st_rd_bank0 = bus.rd_bank; st_valid0 = bus.m_tvalid; st_rel0 = bus.bank_release;
      end
      if (prev_stall && (!bus.m_tvalid || bus.m_tdata !== prev_data || bus.m_tlast !== prev_last))
        st_stall_err++;
      if (bus.ram_en) begin
        issued++;
        st_addrs.push_back(int'(bus.ram_addr));
        if (st_first_en < 0) st_first_en = cyc_n;
      end
      if (bus.m_tvalid && st_first_valid < 0) st_first_valid = cyc_n;
      if (bus.m_tvalid && bus.m_tready) begin
        popped++;
        st_words.push_back(int'(bus.m_tdata));
        st_lasts.push_back(bus.m_tlast);
        st_last_hs = cyc_n;
      end
      if (issued - popped > 2) st_ovf++;
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
      prev_last  = bus.m_tlast;
      if (bus.bank_release != 2'b00) begin
        st_rel_val = bus.bank_release; st_rel_cyc = cyc_n; st_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [DATA_W+ADDR_W+7:0] outs;
    cyc(2'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(2'($urandom), 1'($urandom), 1'b1);
      n_checks++;
      if (bus.ram_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_ram_en[%0d]: got %0b, want 0", i, bus.ram_en);
      end
    end
    outs = {bus.bank_release, bus.ram_en, bus.ram_addr, bus.m_tvalid, bus.m_tdata,
            bus.m_tlast, bus.rd_bank, bus.busy};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rel=%b en=%b addr=%0d vld=%b data=%0d last=%b bank=%b busy=%b, want all 0",
               bus.bank_release, bus.ram_en, bus.ram_addr, bus.m_tvalid, bus.m_tdata,
               bus.m_tlast, bus.rd_bank, bus.busy);
    end
  endtask

  task automatic test_single_bank();
    do_reset();
    stream_bank(2'b01, 0, 3000);
    n_checks++;
    if (st_timeout) begin n_fail++; $display("FAIL single_timeout: no release within budget"); end
    n_checks++;
    if (st_first_en - st_c0 != 1) begin
      n_fail++; $display("FAIL single_first_en: got +%0d cycles, want +1", st_first_en - st_c0);
    end
    n_checks++;
    if (st_first_valid - st_c0 != 3) begin
      n_fail++; $display("FAIL single_first_valid: got +%0d cycles, want +3", st_first_valid - st_c0);
    end
    n_checks++;
    if (st_words.size() != DEPTH) begin
      n_fail++; $display("FAIL single_count: got %0d words, want %0d", st_words.size(), DEPTH);
    end
    for (int k = 0; k < st_words.size() && k < DEPTH; k++) begin
      n_checks++;
      if (st_words[k] != exp_word(0, k) || st_lasts[k] != (k == DEPTH-1)) begin
        n_fail++;
        $display("FAIL single_word[%0d]: got data %0d last %0b, want data %0d last %0b",
                 k, st_words[k], st_lasts[k], exp_word(0, k), (k == DEPTH-1));
      end
    end
    n_checks++;
    if (st_last_hs - st_first_valid != DEPTH-1) begin
      n_fail++; $display("FAIL single_no_bubbles: got span %0d, want %0d", st_last_hs - st_first_valid, DEPTH-1);
    end
    n_checks++;
    if (st_rel_val !== 2'b01 || st_rel_cyc != st_last_hs + 1) begin
      n_fail++;
      $display("FAIL single_release: got %b at +%0d after last handshake, want 01 at +1",
               st_rel_val, st_rel_cyc - st_last_hs);
    end
    cyc(2'b00, 1'b1, 1'b0);
    n_checks++;
    if (bus.bank_release !== 2'b00 || bus.rd_bank !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after_release: got rel=%b bank=%b busy=%b, want rel=00 bank=1 busy=0",
               bus.bank_release, bus.rd_bank, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    stream_bank(2'b01, 30, 8000);
    n_checks++;
    if (st_timeout) begin n_fail++; $display("FAIL bp_timeout: no release within budget"); end
    n_checks++;
    if (st_words.size() != DEPTH) begin
      n_fail++; $display("FAIL bp_count: got %0d words, want %0d", st_words.size(), DEPTH);
    end
    for (int k = 0; k < st_words.size() && k < DEPTH; k++) begin
      n_checks++;
      if (st_words[k] != exp_word(0, k) || st_lasts[k] != (k == DEPTH-1)) begin
        n_fail++;
        $display("FAIL bp_word[%0d]: got data %0d last %0b, want data %0d last %0b",
                 k, st_words[k], st_lasts[k], exp_word(0, k), (k == DEPTH-1));
      end
    end
    n_checks++;
    if (st_stall_err != 0) begin
      n_fail++; $display("FAIL bp_stall_stable: got %0d unstable stall cycles, want 0", st_stall_err);
    end
    n_checks++;
    if (st_ovf != 0) begin
      n_fail++; $display("FAIL bp_outstanding: got %0d cycles above 2 outstanding, want 0", st_ovf);
    end
    n_checks++;
    if (st_rel_val !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: got %b, want 01", st_rel_val);
    end
  endtask

  task automatic test_both_banks();
    int rel1;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      stream_bank(2'b11, 0, 3000);
      n_checks++;
      if (st_rd_bank0 !== b[0]) begin
        n_fail++; $display("FAIL both_rd_bank[%0d]: got %b, want %0d", b, st_rd_bank0, b);
      end
      n_checks++;
      if (st_addrs.size() != DEPTH) begin
        n_fail++; $display("FAIL both_addr_count[%0d]: got %0d reads, want %0d", b, st_addrs.size(), DEPTH);
      end
      for (int k = 0; k < st_addrs.size() && k < DEPTH; k++) begin
        n_checks++;
        if (st_addrs[k] != exp_word(b, k)) begin
          n_fail++; $display("FAIL both_addr[%0d][%0d]: got %0d, want %0d", b, k, st_addrs[k], exp_word(b, k));
        end
      end
      n_checks++;
      if (st_rel_val !== (b == 0 ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL both_release[%0d]: got %b, want %b", b, st_rel_val, (b == 0 ? 2'b01 : 2'b10));
      end
      if (b == 1) begin
        n_checks++;
        if (st_first_en != rel1 + 2) begin
          n_fail++; $display("FAIL both_gap: got first ram_en +%0d after release, want +2", st_first_en - rel1);
        end
      end
      rel1 = st_rel_cyc;
    end
  endtask

  task automatic test_out_of_order();
    int en_cnt = 0;
    int busy_cnt = 0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cyc(2'b10, 1'b1, 1'b0);
      if (bus.ram_en) en_cnt++;
      if (bus.busy) busy_cnt++;
    end
    n_checks++;
    if (en_cnt != 0 || busy_cnt != 0) begin
      n_fail++; $display("FAIL ooo_idle: got %0d ram_en and %0d busy cycles, want 0 and 0", en_cnt, busy_cnt);
    end
    stream_bank(2'b11, 0, 3000);
    n_checks++;
    if (st_addrs.size() != DEPTH || st_addrs[0] != 0 || st_addrs[DEPTH-1] != DEPTH-1) begin
      n_fail++;
      $display("FAIL ooo_bank0_first: got %0d reads starting at %0d, want %0d reads from 0",
               st_addrs.size(), (st_addrs.size() > 0) ? st_addrs[0] : -1, DEPTH);
    end
    n_checks++;
    if (st_rel_val !== 2'b01) begin
      n_fail++; $display("FAIL ooo_release: got %b, want 01", st_rel_val);
    end
  endtask

  task automatic test_mid_reset();
    int accepted = 0;
    do_reset();
    for (int i = 0; i < 2000 && accepted < 501; i++) begin
      cyc(2'b01, 1'b1, 1'b0);
      if (bus.m_tvalid && bus.m_tready) accepted++;
    end
    n_checks++;
    if (accepted != 501) begin
      n_fail++; $display("FAIL midrst_progress: got %0d words before reset, want 501", accepted);
    end
    cyc(2'b01, 1'b1, 1'b1);
    stream_bank(2'b11, 0, 3000);
    n_checks++;
    if (st_valid0 !== 1'b0 || st_rel0 !== 2'b00 || st_rd_bank0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: got valid=%b rel=%b bank=%b, want valid=0 rel=00 bank=0",
               st_valid0, st_rel0, st_rd_bank0);
    end
    n_checks++;
    if (st_words.size() != DEPTH) begin
      n_fail++; $display("FAIL midrst_count: got %0d words, want %0d", st_words.size(), DEPTH);
    end
    for (int k = 0; k < st_words.size() && k < DEPTH; k++) begin
      n_checks++;
      if (st_words[k] != exp_word(0, k) || st_addrs[k] != exp_word(0, k)) begin
        n_fail++;
        $display("FAIL midrst_word[%0d]: got data %0d addr %0d, want %0d", k, st_words[k], st_addrs[k], exp_word(0, k));
      end
    end
    n_checks++;
    if (st_rel_val !== 2'b01) begin
      n_fail++; $display("FAIL midrst_release: got %b, want 01", st_rel_val);
    end
  endtask

  initial begin
    bus.bank_full = 2'b00;
    bus.m_tready  = 1'b0;
    test_reset();
    test_single_bank();
    test_backpressure();
    test_both_banks();
    test_out_of_order();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $fatal(1, "watchdog expired");
  end

endmodule
